// File: rtl/tstate_ring_counter.sv
// tstate_ring_counter
//
// Parametrised T-state generator for the NSC-8 control sequencer. It keeps a
// binary state index and decodes it into a one-hot timing ring. The decoder
// sets the active length of each instruction through `len`, so an instruction
// can end before the ring reaches its last bit.
//
// Ports:
//   clk          system clock, rising edge
//   reset_ring_n asynchronous active-low reset
//   enable       advance permission; low holds the ring
//   restart      synchronous return to T0; ignores enable
//   halt         freeze request (HLT); sets the sticky halted flag
//   len          index of the last T-state of the current instruction
//   count_out    one-hot T-state, bit k = Tk
//   t_index      binary index of the active T-state
//   t_last       active state is the last one of this instruction (combinational)
//   cycle_start  one-clock strobe: ring just entered T0 by wrap or restart
//   halted       sticky halt status, cleared only by reset
//   cycle_count  completed instructions, modulo 2^CW

module tstate_ring_counter #(
   parameter int unsigned N  = 6,
   parameter int unsigned IW = $clog2(N),
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          reset_ring_n,
   input  logic          enable,
   input  logic          restart,
   input  logic          halt,
   input  logic [IW-1:0] len,
   output logic [N-1:0]  count_out,
   output logic [IW-1:0] t_index,
   output logic          t_last,
   output logic          cycle_start,
   output logic          halted,
   output logic [CW-1:0] cycle_count
);

   localparam logic [IW-1:0] LastIdx = IW'(N - 1);

   logic [IW-1:0] t_idx_q, t_idx_d;
   logic          cycle_start_q, cycle_start_d;
   logic          halted_q, halted_d;
   logic [CW-1:0] cycle_count_q, cycle_count_d;
   logic [IW-1:0] end_eff;

   // Lengths beyond the ring are clamped to the last physical T-state.
   assign end_eff = (len > LastIdx) ? LastIdx : len;

   // Compare with >= so that lowering len below the current index mid-instruction
   // still ends the instruction at the next advance.
   assign t_last = (t_idx_q >= end_eff);

   always_comb begin
      t_idx_d       = t_idx_q;
      cycle_start_d = 1'b0;
      halted_d      = halted_q;
      cycle_count_d = cycle_count_q;

      if (halted_q) begin
         // Fully frozen until reset; cycle_start is already low here.
         cycle_start_d = cycle_start_q;
      end else if (halt) begin
         halted_d = 1'b1;
      end else if (restart) begin
         t_idx_d       = '0;
         cycle_start_d = 1'b1;
      end else if (enable) begin
         if (t_last) begin
            t_idx_d       = '0;
            cycle_start_d = 1'b1;
            cycle_count_d = cycle_count_q + CW'(1);
         end else begin
            // t_last low guarantees t_idx_q < end_eff <= N-1, so no overflow.
            t_idx_d = t_idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_ring_n) begin
      if (!reset_ring_n) begin
         t_idx_q       <= '0;
         cycle_start_q <= 1'b0;
         halted_q      <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         t_idx_q       <= t_idx_d;
         cycle_start_q <= cycle_start_d;
         halted_q      <= halted_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Decoded straight from the index register, so the ring is one-hot by construction.
   assign count_out   = N'(1) << t_idx_q;
   assign t_index     = t_idx_q;
   assign cycle_start = cycle_start_q;
   assign halted      = halted_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_tstate_ring_counter.sv
// Testbench for tstate_ring_counter (N=6, CW=8).
// A table of {inputs, expected outputs} records is applied one per clock.
// Reset records assert reset_ring_n between edges and check the reset state
// immediately, before any clock edge.

module tb_tstate_ring_counter;

   localparam int unsigned N  = 6;
   localparam int unsigned IW = 3;
   localparam int unsigned CW = 8;

   typedef struct {
      logic          is_rst;
      logic          en;
      logic          rs;
      logic          ht;
      logic [IW-1:0] ln;
      logic          pre_last;   // t_last expected before the edge
      logic [N-1:0]  cnt;        // expected after the edge
      logic [IW-1:0] idx;
      logic          cs;
      logic          hlt;
      logic [CW-1:0] cc;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_ring_n;
   logic          enable;
   logic          restart;
   logic          halt;
   logic [IW-1:0] len;
   logic [N-1:0]  count_out;
   logic [IW-1:0] t_index;
   logic          t_last;
   logic          cycle_start;
   logic          halted;
   logic [CW-1:0] cycle_count;

   int n_vec = 0;
   int n_err = 0;

   vec_t tbl[$];
   vec_t sb[$];

   tstate_ring_counter #(
      .N  (N),
      .IW (IW),
      .CW (CW)
   ) dut (
      .clk          (clk),
      .reset_ring_n (reset_ring_n),
      .enable       (enable),
      .restart      (restart),
      .halt         (halt),
      .len          (len),
      .count_out    (count_out),
      .t_index      (t_index),
      .t_last       (t_last),
      .cycle_start  (cycle_start),
      .halted       (halted),
      .cycle_count  (cycle_count)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   function automatic vec_t v(input logic en, input logic rs, input logic ht, input int ln,
                              input logic pre_last, input int idx, input logic cs,
                              input logic hlt, input int cc);
      vec_t r;
      r.is_rst   = 1'b0;
      r.en       = en;
      r.rs       = rs;
      r.ht       = ht;
      r.ln       = IW'(ln);
      r.pre_last = pre_last;
      r.cnt      = onehot(idx);
      r.idx      = IW'(idx);
      r.cs       = cs;
      r.hlt      = hlt;
      r.cc       = CW'(cc);
      return r;
   endfunction

   function automatic vec_t rv(input logic en, input int ln);
      vec_t r;
      r = v(en, 1'b0, 1'b0, ln, 1'b0, 0, 1'b0, 1'b0, 0);
      r.is_rst = 1'b1;
      return r;
   endfunction

   task automatic chk(input string name, input int vi, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s vec %0d: got %0h, expected %0h", name, vi, act, exp);
      end
   endtask

   task automatic chk_outputs(input int vi);
      vec_t e;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard vec %0d: got empty queue, expected an entry", vi);
      end else begin
         e = sb.pop_front();
         chk("count_out",   vi, 32'(count_out),   32'(e.cnt));
         chk("t_index",     vi, 32'(t_index),     32'(e.idx));
         chk("cycle_start", vi, 32'(cycle_start), 32'(e.cs));
         chk("halted",      vi, 32'(halted),      32'(e.hlt));
         chk("cycle_count", vi, 32'(cycle_count), 32'(e.cc));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_ring_n = 1'b0;
      enable       = 1'b0;
      restart      = 1'b0;
      halt         = 1'b0;
      len          = '0;

      // Full walk with len=5.
      tbl.push_back(rv(1'b1, 5));
      for (int k = 1; k <= 5; k++) tbl.push_back(v(1, 0, 0, 5, 0, k, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 5, 1, 0, 1, 0, 1));

      // Over-range len=7 behaves as len=5.
      tbl.push_back(rv(1'b1, 7));
      for (int k = 1; k <= 5; k++) tbl.push_back(v(1, 0, 0, 7, 0, k, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 7, 1, 0, 1, 0, 1));

      // len=2 for four instructions.
      tbl.push_back(rv(1'b1, 2));
      for (int i = 1; i <= 4; i++) begin
         tbl.push_back(v(1, 0, 0, 2, 0, 1, 0, 0, i - 1));
         tbl.push_back(v(1, 0, 0, 2, 0, 2, 0, 0, i - 1));
         tbl.push_back(v(1, 0, 0, 2, 1, 0, 1, 0, i));
      end

      // Hold at T3, then lower len below the index.
      tbl.push_back(rv(1'b1, 5));
      for (int k = 1; k <= 3; k++) tbl.push_back(v(1, 0, 0, 5, 0, k, 0, 0, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(v(0, 0, 0, 5, 0, 3, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 3, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 1, 0, 1));

      // Restart at T4 with enable low, then restart beating a wrap.
      tbl.push_back(rv(1'b1, 5));
      for (int k = 1; k <= 4; k++) tbl.push_back(v(1, 0, 0, 5, 0, k, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 5, 0, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 5, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0));

      // Halt in T2 after one completed instruction; frozen; async reset clears it.
      tbl.push_back(rv(1'b1, 1));
      tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 1, 0, 1));
      tbl.push_back(v(1, 0, 0, 5, 0, 1, 0, 0, 1));
      tbl.push_back(v(1, 0, 0, 5, 0, 2, 0, 0, 1));
      tbl.push_back(v(1, 0, 1, 5, 0, 2, 0, 1, 1));
      tbl.push_back(v(1, 1, 0, 5, 0, 2, 0, 1, 1));
      tbl.push_back(v(1, 0, 0, 0, 1, 2, 0, 1, 1));
      tbl.push_back(v(0, 0, 1, 3, 0, 2, 0, 1, 1));
      tbl.push_back(rv(1'b1, 5));
      tbl.push_back(v(1, 0, 0, 5, 0, 1, 0, 0, 0));

      // len=0: every enabled edge completes an instruction; counter wraps 255 -> 0.
      tbl.push_back(rv(1'b1, 0));
      for (int k = 1; k <= 258; k++) tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, k % 256));
      tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 2));
      tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 3));
      tbl.push_back(v(1, 0, 1, 0, 1, 0, 0, 1, 3));

      foreach (tbl[i]) begin
         @(negedge clk);
         enable  = tbl[i].en;
         restart = tbl[i].rs;
         halt    = tbl[i].ht;
         len     = tbl[i].ln;
         n_vec++;
         if (tbl[i].is_rst) begin
            reset_ring_n = 1'b0;
            #1;
            sb.push_back(tbl[i]);
            chk_outputs(i);
            chk("t_last_rst", i, 32'(t_last), 32'(tbl[i].ln == 0));
            @(posedge clk);
            #1;
            reset_ring_n = 1'b1;
         end else begin
            #1;
            chk("t_last", i, 32'(t_last), 32'(tbl[i].pre_last));
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            chk_outputs(i);
         end
      end

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tstate_ring_counter.md
Name: tstate_ring_counter

Overview:
Parametrised T-state generator for the NSC-8 control sequencer and successor to the fixed 6-state ring counter. It drives a one-hot timing ring whose active length is set per instruction by the decoder, so instructions can end early. It adds clock-enable, synchronous restart, a sticky halt, a binary state index, a cycle-start strobe and a completed-instruction counter. It sits between the instruction decoder and the control-word ROM/logic.

Parameters:
N, 6, number of T-states (ring width); legal range 2..32.
IW, $clog2(N), width of the state index and `len`.
CW, 8, width of the completed-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
reset_ring_n  in  1  asynchronous active-low reset.
enable  in  1  advance permission; low holds the ring.
restart  in  1  synchronous return to T0; ignores enable.
halt  in  1  request to freeze the ring (HLT instruction).
len  in  IW  index of the last T-state of the current instruction; decoder drives it combinationally.
count_out  out  N  one-hot T-state; bit k = Tk.
t_index  out  IW  binary index of the active T-state.
t_last  out  1  active state is the last state of this instruction (combinational).
cycle_start  out  1  registered one-clock strobe: ring just entered T0 by wrap or restart.
halted  out  1  sticky halt status.
cycle_count  out  CW  number of completed instructions, modulo 2^CW.

Behaviour:
- State is held as a binary index register; `count_out` = 1 << t_index, so it is always one-hot.
- Reset (reset_ring_n=0, asynchronous, takes effect immediately):
  - t_index=0, count_out=1 (T0)
  - halted=0, cycle_start=0, cycle_count=0
- Effective end: end_eff = min(len, N-1).
  - t_last = (t_index >= end_eff); it reacts to `len` in the same cycle.
  - If `len` is lowered below the current index mid-instruction, the ring ends at the next advance.
- Edge priority, highest first:
  1. halted=1: everything is frozen; restart, enable and len are ignored.
  2. halt=1: halted<=1, ring holds its current state, no count change, cycle_start<=0.
  3. restart=1: t_index<=0, cycle_start<=1, cycle_count unchanged, regardless of enable.
  4. enable=1 and t_last=1: t_index<=0, cycle_start<=1, cycle_count<=cycle_count+1 (wraps to 0).
  5. enable=1 and t_last=0: t_index<=t_index+1, cycle_start<=0.
  6. enable=0: hold state, cycle_start<=0.
- len=0: the ring stays in T0. Every enabled edge counts one instruction and keeps cycle_start high.
- halted clears only on reset.
- All outputs are registered except `t_last`. There is no latency beyond one clock per advance.
- Reset released with enable=1 starts in T0. The first advance happens on the first edge after release.

Test Plan:
- N=6, len=5, enable=1 after reset -> count_out walks 000001, 000010, 000100, 001000, 010000, 100000, 000001. t_last is high only in T5. cycle_start pulses in the wrapped T0. cycle_count=1.
- len=2 for 4 instructions -> repeating T0,T1,T2. t_index runs 0,1,2. cycle_count=4 after 12 enabled clocks.
- At T3, enable=0 for 3 clocks -> count_out holds 001000. Then len changes 5->1 -> t_last=1 immediately. Next enabled edge gives T0, with cycle_start=1 and cycle_count+1.
- Boundary lengths:
  - len=7 (over range) -> behaves as len=5.
  - len=0 -> count_out stays 000001, cycle_start stays 1, cycle_count rises every clock.
  - 256 such clocks -> cycle_count wraps 255 -> 0.
- restart=1 at T4 with enable=0 -> T0 next edge, cycle_start=1, cycle_count unchanged.
- halt=1 in T2 -> halted=1 and count_out frozen at 000100 despite enable/restart. Asserting reset_ring_n=0 between edges -> count_out=000001, halted=0, cycle_count=0 before the next clk edge.
